// File: rtl/operand_sequencer_if.sv
// Instruction-memory request/response bundle between the operand sequencer and memory.
interface operand_sequencer_if;
  logic [7:0]  im_addr;
  logic        im_req;
  logic [18:0] im_data;
  logic        im_valid;

  modport master (
    output im_addr,
    output im_req,
    input  im_data,
    input  im_valid
  );

  modport slave (
    input  im_addr,
    input  im_req,
    output im_data,
    output im_valid
  );
endinterface

// File: rtl/operand_sequencer.sv
// Fetch/decode controller: walks the PC through instruction memory, latches each word
// and drives operand selects, immediate, ALU opcode and one-cycle register load strobes.
module operand_sequencer (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  operand_sequencer_if.master        im,
  output logic [1:0]                 sel_a,
  output logic [1:0]                 sel_b,
  output logic [2:0]                 alu_op,
  output logic [7:0]                 imm,
  output logic                       load_a,
  output logic                       load_b,
  output logic                       halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  pc;
  logic [7:0]  pc_next;
  logic [18:0] ir;
  logic [18:0] ir_next;

  logic        ir_halt;
  logic        ir_jmp;

  assign ir_halt = ir[18];
  assign ir_jmp  = ir[17];

  // Selects are pure decodes of IR, so they stay put from EXEC until the next latch.
  assign sel_a      = ir[14:13];
  assign sel_b      = (ir[12:11] == 2'b11) ? 2'b00 : ir[12:11];
  assign alu_op     = ir[10:8];
  assign imm        = ir[7:0];
  assign im.im_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= 8'h00;
      ir    <= 19'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    im.im_req  = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    halted     = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        im.im_req = 1'b1;
        if (im.im_valid) begin
          ir_next    = im.im_data;
          state_next = EXEC;
        end
      end

      EXEC: begin
        // Halt outranks jump and loads: PC frozen, no strobes.
        if (ir_halt) begin
          state_next = HALT;
        end else begin
          load_a     = ir[16] & ~ir_jmp;
          load_b     = ir[15] & ~ir_jmp;
          pc_next    = ir_jmp ? ir[7:0] : pc + 8'd1;
          state_next = run ? FETCH : IDLE;
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: bench-owned instruction memory with random
// wait states, checked against an instruction-level model of PC flow and decode rules.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [2:0] alu_op;
  logic [7:0] imm;
  logic       load_a;
  logic       load_b;
  logic       halted;

  operand_sequencer_if bus ();

  operand_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .im     (bus),
    .sel_a  (sel_a),
    .sel_b  (sel_b),
    .alu_op (alu_op),
    .imm    (imm),
    .load_a (load_a),
    .load_b (load_b),
    .halted (halted)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  logic [18:0] mem [256];
  int          mpc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [18:0] d);
    run          = r;
    bus.im_valid = v;
    bus.im_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".im_addr"}, 32'(bus.im_addr), 0);
    checkOutput({tag, ".im_req"},  32'(bus.im_req),  0);
    checkOutput({tag, ".sel_a"},   32'(sel_a),       0);
    checkOutput({tag, ".sel_b"},   32'(sel_b),       0);
    checkOutput({tag, ".alu_op"},  32'(alu_op),      0);
    checkOutput({tag, ".imm"},     32'(imm),         0);
    checkOutput({tag, ".load_a"},  32'(load_a),      0);
    checkOutput({tag, ".load_b"},  32'(load_b),      0);
    checkOutput({tag, ".halted"},  32'(halted),      0);
  endtask

  function automatic logic [18:0] mk(input logic h, input logic j, input logic la,
                                     input logic lb, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] op,
                                     input logic [7:0] lit);
    return {h, j, la, lb, sa, sb, op, lit};
  endfunction

  function automatic int selBRule(input logic [1:0] code);
    if (code == 2'b11) return 0;
    return int'(code);
  endfunction

  // IDLE -> FETCH takes one edge; stray im_valid while idle must be ignored.
  task automatic restart();
    applyStimulus(1'b1, 1'b1, 19'($urandom));
    step();
    applyStimulus(1'b1, 1'b0, 19'h0);
    checkOutput("restart.im_req",  32'(bus.im_req),  1);
    checkOutput("restart.im_addr", 32'(bus.im_addr), 32'(mpc));
  endtask

  // Entered with the DUT in FETCH; serves one instruction after 'waits' idle memory cycles.
  task automatic runInstr(input int waits, input bit dropRun, input string tag);
    logic [18:0] w;
    int          nextPc;
    bit          h;
    bit          j;
    for (int i = 0; i < waits; i++) begin
      checkOutput({tag, ".wait_req"},  32'(bus.im_req),  1);
      checkOutput({tag, ".wait_addr"}, 32'(bus.im_addr), 32'(mpc));
      applyStimulus((dropRun && i == 0) ? 1'b0 : run, 1'b0, 19'($urandom));
      step();
    end
    checkOutput({tag, ".req"},  32'(bus.im_req),  1);
    checkOutput({tag, ".addr"}, 32'(bus.im_addr), 32'(mpc));
    w = mem[mpc[7:0]];
    applyStimulus(dropRun ? 1'b0 : run, 1'b1, w);
    step();
    h = w[18];
    j = w[17];
    applyStimulus(run, 1'b1, ~w);
    checkOutput({tag, ".exec_req"}, 32'(bus.im_req), 0);
    checkOutput({tag, ".load_a"},   32'(load_a), (h || j) ? 0 : 32'(w[16]));
    checkOutput({tag, ".load_b"},   32'(load_b), (h || j) ? 0 : 32'(w[15]));
    checkOutput({tag, ".sel_a"},    32'(sel_a),  32'(w[14:13]));
    checkOutput({tag, ".sel_b"},    32'(sel_b),  32'(selBRule(w[12:11])));
    checkOutput({tag, ".alu_op"},   32'(alu_op), 32'(w[10:8]));
    checkOutput({tag, ".imm"},      32'(imm),    32'(w[7:0]));
    checkOutput({tag, ".halted0"},  32'(halted), 0);
    if (h)      nextPc = mpc;
    else if (j) nextPc = int'(w[7:0]);
    else        nextPc = (mpc + 1) % 256;
    step();
    applyStimulus(run, 1'b0, 19'h0);
    mpc = nextPc;
    checkOutput({tag, ".post_load_a"}, 32'(load_a), 0);
    checkOutput({tag, ".post_load_b"}, 32'(load_b), 0);
    checkOutput({tag, ".post_imm"},    32'(imm),    32'(w[7:0]));
    if (h) begin
      checkOutput({tag, ".halted"},   32'(halted),     1);
      checkOutput({tag, ".halt_req"}, 32'(bus.im_req), 0);
    end else begin
      checkOutput({tag, ".halted"},   32'(halted),      0);
      checkOutput({tag, ".next_req"}, 32'(bus.im_req),  32'(run));
      checkOutput({tag, ".next_pc"},  32'(bus.im_addr), 32'(mpc));
    end
  endtask

  initial begin
    logic [18:0] w;
    int          waits;
    bit          drop;

    for (int i = 0; i < 256; i++) begin
      w      = 19'($urandom);
      w[18]  = 1'b0;
      mem[i] = w;
    end
    mem[0]   = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 3'd0, 8'h2A);
    mem[1]   = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 3'd3, 8'h11);
    mem[2]   = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b11, 3'd5, 8'h5C);
    mem[3]   = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01, 3'd7, 8'hFF);
    mem[255] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 3'd2, 8'h77);

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 19'h0);
    step();
    step();
    rst_n = 1'b1;
    checkAllZero("reset");
    for (int i = 0; i < 5; i++) begin
      step();
      checkAllZero("idle");
    end
    mpc = 0;

    $display("[TB] straight-line, wait states, jump and wrap");
    restart();
    runInstr(0, 1'b0, "prog0");
    runInstr(0, 1'b0, "prog1");
    runInstr(3, 1'b0, "wait_selb11");
    runInstr(0, 1'b0, "jmp_ff");
    runInstr(0, 1'b0, "wrap");

    $display("[TB] halt priority");
    mem[1] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 3'd1, 8'h40);
    runInstr(0, 1'b0, "prog0_again");
    runInstr(0, 1'b0, "halt");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 19'($urandom));
      step();
      checkOutput("halt_hold.halted", 32'(halted),      1);
      checkOutput("halt_hold.im_req", 32'(bus.im_req),  0);
      checkOutput("halt_hold.load_a", 32'(load_a),      0);
      checkOutput("halt_hold.im_addr", 32'(bus.im_addr), 1);
    end
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 19'h0);
    step();
    rst_n = 1'b1;
    checkAllZero("halt_reset");
    mpc = 0;

    $display("[TB] run drop and mid-fetch reset");
    mem[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 3'd4, 8'h99);
    restart();
    runInstr(2, 1'b1, "rundrop");
    step();
    checkOutput("rundrop.idle_req",  32'(bus.im_req),  0);
    checkOutput("rundrop.idle_addr", 32'(bus.im_addr), 1);
    restart();
    applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 3'd6, 8'hAB));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 19'h0);
    checkAllZero("midreset");
    step();
    checkAllZero("midreset_after");
    mpc = 0;

    $display("[TB] randomized program flow");
    restart();
    for (int n = 0; n < 150; n++) begin
      w          = 19'($urandom);
      w[18]      = 1'b0;
      mem[mpc]   = w;
      waits      = $urandom_range(0, 3);
      drop       = ($urandom_range(0, 7) == 0);
      runInstr(waits, drop, "rand");
      if (!run) restart();
    end
    w        = 19'($urandom);
    w[18]    = 1'b1;
    mem[mpc] = w;
    runInstr($urandom_range(0, 3), 1'b0, "rand_halt");
    step();
    checkOutput("rand_halt.hold", 32'(halted), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
